// File: rtl/serial_subtractor_if.sv
// Handshake bundle for serial_subtractor: operand request side plus result side.
// The overflow signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             borrowout;
  logic             out_valid;
  logic             out_ready;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, a, b, out_ready,
    input  in_ready, diff, borrowout, out_valid, overflow
  );
  modport slave (
    input  start, a, b, out_ready,
    output in_ready, diff, borrowout, out_valid, overflow
  );
`else
  modport master (
    output start, a, b, out_ready,
    input  in_ready, diff, borrowout, out_valid
  );
  modport slave (
    input  start, a, b, out_ready,
    output in_ready, diff, borrowout, out_valid
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one bit per clock, LSB first, result held until consumed.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed overflow output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             r_a_msb;
  logic             r_b_msb;
`endif

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start)     w_next = S_SHIFT;
      S_SHIFT: if (w_last)        w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a    <= bus.a;
      r_b    <= bus.b;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
`endif
    end else if (r_state == S_SHIFT) begin
      // Difference bits enter at the MSB so after WIDTH shifts bit 0 lands at LSB.
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_a    <= {1'b0, r_a[WIDTH-1:1]};
      r_b    <= {1'b0, r_b[WIDTH-1:1]};
      r_br   <= w_br_next;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.diff      = (r_state == S_DONE) ? r_diff : '0;
    bus.borrowout = (r_state == S_DONE) && r_br;
`ifdef SERIAL_SUB_OVERFLOW_EN
    bus.overflow  = (r_state == S_DONE) && (r_a_msb != r_b_msb) &&
                    (r_diff[WIDTH-1] != r_a_msb);
`endif
  end

endmodule
